demux_rr_dispatcher: RTL and testbench
======================================

Name: demux_rr_dispatcher

Overview:
Round-robin dispatcher that sequences the 1-to-8 demux datapath. It accepts a single valid/ready input stream and distributes words across 8 destination channels. Each channel receives a burst of BURST_LEN consecutive words before the grant rotates to the next enabled channel. The block drives the demux select and a registered one-hot valid, and holds each word until the addressed channel accepts it.

Parameters:
DATA_W, 8, width of data words
BURST_LEN, 1, words sent to one channel before rotating (legal range 1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word available
in_data  input  DATA_W  upstream word
in_ready  output  1  dispatcher can accept a word this cycle
ch_en  input  8  per-channel enable mask; bit k=1 means channel k takes part in rotation
out_ready  input  8  per-channel ready from destinations
out_valid  output  8  one-hot; bit k=1 means out_data is held for channel k
out_data  output  DATA_W  registered word, broadcast to all channels
sel  output  3  demux select, equal to the index of the held word's channel
busy  output  1  a word is held (equals |out_valid)

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, sel=0, busy=0.
  - Internal rotation pointer ptr=7; burst counter bcnt=BURST_LEN. This forces a rotation on the first accept.
- FSM states:
  - EMPTY: no word held.
  - FULL: one word held in out_data.
- Definitions:
  - drain = FULL && out_ready[sel].
  - in_ready = (ch_en != 0) && (EMPTY || drain). in_ready is combinational from out_ready and ch_en.
  - accept = in_valid && in_ready.
- Target selection (combinational, evaluated on accept):
  - If bcnt < BURST_LEN and ch_en[ptr]=1, then tgt=ptr.
  - Otherwise tgt is the first enabled channel scanning ptr+1, ptr+2, ... modulo 8, wrapping 7->0. Scanning may return ptr itself if it is the only enabled channel.
- On accept (registered, latency 1):
  - out_data<=in_data, sel<=tgt, out_valid<=1<<tgt, ptr<=tgt.
  - bcnt<=1 if tgt!=ptr or a rotation occurred; otherwise bcnt<=bcnt+1.
  - bcnt saturates at BURST_LEN.
- State transitions:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on drain with accept. This is back-to-back transfer: 1 word/cycle when out_ready is held high.
  - FULL -> EMPTY on drain without accept. out_valid<=0; out_data holds its last value.
  - FULL with no drain: out_data, sel and out_valid stay stable. in_ready=0.
- Boundary conditions:
  - ch_en==0: in_ready=0, no accept. A held word still drains normally.
  - Channel disabled while its word is held: the word is still delivered. Disable affects only future target selection.
  - Channel disabled mid-burst: the burst is abandoned and the next accept rotates.
  - Channel enabled mid-rotation: it participates from the next target evaluation.
  - out_ready bits for channels other than sel are ignored.
  - BURST_LEN=1: the channel changes on every accept.
  - rst_n asserted mid-transfer: the held word is discarded immediately and all outputs return to their reset values asynchronously. After release, the first accept goes to the lowest enabled channel index.
- Data is never duplicated or dropped: each accepted word appears exactly once on exactly one channel.

Test Plan:
- Reset, ch_en=8'hFF, BURST_LEN=1, out_ready=8'hFF, send 0x10..0x17 on consecutive cycles -> out_valid sequence 01,02,04,...,80 one cycle after each accept; out_data=0x10..0x17; sel=0..7; in_ready held high.
- ch_en=8'b1010_0100, BURST_LEN=2, out_ready=FF, send 8 words -> sel sequence 2,2,5,5,7,7,2,2 (wrap 7->2).
- Word 0xAA held for channel 3 with out_ready[3]=0 for 5 cycles while in_valid=1 -> out_data stays 0xAA, out_valid=08, in_ready=0. Raise out_ready[3] -> next word accepted the same cycle and sel advances to 4.
- ch_en=0 with in_valid=1 for 4 cycles -> in_ready=0, out_valid=0. Set ch_en=8'h40 -> the next word goes to channel 6.
- BURST_LEN=3, ch_en=FF: after 2 words to channel 0, clear ch_en[0] -> the third word goes to channel 1 and bcnt restarts, so channel 1 takes 3 words.
- Assert rst_n=0 asynchronously mid-cycle while FULL for channel 5 -> out_valid=0, sel=0, out_data=0 without waiting for a clock edge. After release, the first word with ch_en=FF goes to channel 0.

Source files
------------

// File: rtl/demux_rr_if.sv
// Handshake bundle between the upstream stream, the dispatcher and the 8 destination channels.
// The slave modport is the dispatcher's view; the master modport is the surrounding environment.
interface demux_rr_if #(
  parameter int unsigned DATA_W = 8
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [7:0]        ch_en;
  logic [7:0]        out_ready;
  logic [7:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        sel;
  logic              busy;

  modport slave (
    input  in_valid,
    input  in_data,
    input  ch_en,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output sel,
    output busy
  );

  modport master (
    output in_valid,
    output in_data,
    output ch_en,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  sel,
    input  busy
  );

endinterface

// File: rtl/demux_rr_dispatcher.sv
// Round-robin 1-to-8 dispatcher: holds one word, steers it with sel/out_valid and
// rotates the grant across enabled channels after every BURST_LEN words.
module demux_rr_dispatcher #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 1
) (
  input logic       clk,
  input logic       rst_n,
  demux_rr_if.slave bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  // First enabled channel after ptr (wrapping); ptr itself is the last candidate.
  function automatic logic [2:0] next_enabled(input logic [7:0] en, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] res;
    res = ptr;
    for (int i = 8; i >= 1; i--) begin
      idx = ptr + 3'(i);
      res = en[idx] ? idx : res;
    end
    return res;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic [2:0]        r_sel;
  logic [2:0]        w_sel_nxt;
  logic [7:0]        r_valid;
  logic [7:0]        w_valid_nxt;
  logic [2:0]        r_ptr;
  logic [2:0]        w_ptr_nxt;
  logic [7:0]        r_bcnt;
  logic [7:0]        w_bcnt_nxt;

  logic              w_drain;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_stay;
  logic [2:0]        w_scan;
  logic [2:0]        w_tgt;

  assign w_drain    = (r_state == ST_FULL) && bus.out_ready[r_sel];
  assign w_in_ready = (bus.ch_en != 8'h00) && ((r_state == ST_EMPTY) || w_drain);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Stay on ptr only mid-burst and while it is still enabled; anything else rotates.
  assign w_stay = (r_bcnt < BURST_MAX) && bus.ch_en[r_ptr];
  assign w_scan = next_enabled(bus.ch_en, r_ptr);
  assign w_tgt  = w_stay ? r_ptr : w_scan;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Held word, steering and rotation registers; reset discards any held word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= {DATA_W{1'b0}};
      r_sel   <= 3'd0;
      r_valid <= 8'h00;
      r_ptr   <= 3'd7;
      r_bcnt  <= BURST_MAX;
    end else begin
      r_data  <= w_data_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_bcnt_nxt  = r_bcnt;

    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
          w_valid_nxt = 8'h00;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_valid_nxt = 8'h00;
      end
    endcase

    if (w_accept) begin
      w_data_nxt  = bus.in_data;
      w_sel_nxt   = w_tgt;
      w_valid_nxt = 8'h01 << w_tgt;
      w_ptr_nxt   = w_tgt;
      if (!w_stay) begin
        w_bcnt_nxt = 8'd1;
      end else if (r_bcnt < BURST_MAX) begin
        w_bcnt_nxt = r_bcnt + 8'd1;
      end else begin
        w_bcnt_nxt = r_bcnt;
      end
    end else begin
      w_bcnt_nxt = r_bcnt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.sel       = r_sel;
  assign bus.busy      = (r_state == ST_FULL);

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Scoreboard bench for demux_rr_dispatcher: three instances cover BURST_LEN = 1, 2 and 3.
module tb_demux_rr_dispatcher;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } sb_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  sb_t  sbq[$];
  sb_t  exp_e;
  logic [7:0] exp_v;

  demux_rr_if #(.DATA_W(8)) b1 ();
  demux_rr_if #(.DATA_W(8)) b2 ();
  demux_rr_if #(.DATA_W(8)) b3 ();

  demux_rr_dispatcher #(.DATA_W(8), .BURST_LEN(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  demux_rr_dispatcher #(.DATA_W(8), .BURST_LEN(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  demux_rr_dispatcher #(.DATA_W(8), .BURST_LEN(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic test_reset;
    rst_n = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = 8'h00; b1.ch_en = 8'hFF; b1.out_ready = 8'hFF;
    b2.in_valid = 1'b0; b2.in_data = 8'h00; b2.ch_en = 8'hFF; b2.out_ready = 8'hFF;
    b3.in_valid = 1'b0; b3.in_data = 8'h00; b3.ch_en = 8'hFF; b3.out_ready = 8'hFF;
    #1;
    checks++;
    if ({b1.out_valid, b1.sel, b1.out_data, b1.busy} !== 20'h0) begin
      failures++;
      $display("FAIL reset_dut1 got v=%h s=%0d d=%h b=%b exp all zero", b1.out_valid, b1.sel, b1.out_data, b1.busy);
    end
    checks++;
    if ({b2.out_valid, b2.sel, b2.out_data, b2.busy, b3.out_valid, b3.sel, b3.out_data, b3.busy} !== 40'h0) begin
      failures++;
      $display("FAIL reset_dut23 got v2=%h v3=%h d2=%h d3=%h exp all zero", b2.out_valid, b3.out_valid, b2.out_data, b3.out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 8'h00) begin
      failures++;
      $display("FAIL reset_release got rdy=%b v=%h exp rdy=1 v=00", b1.in_ready, b1.out_valid);
    end
  endtask

  task automatic test_rotation_b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL rot_sb_empty i=%0d got=empty exp=entry", i);
        end else begin
          exp_e = sbq.pop_front();
          exp_v = 8'h01 << exp_e.sel;
          if (b1.sel !== exp_e.sel || b1.out_data !== exp_e.data || b1.out_valid !== exp_v) begin
            failures++;
            $display("FAIL rot_word i=%0d got s=%0d d=%h v=%h exp s=%0d d=%h v=%h",
                     i, b1.sel, b1.out_data, b1.out_valid, exp_e.sel, exp_e.data, exp_v);
          end
        end
      end
      if (i < 8) begin
        b1.in_valid = 1'b1;
        b1.in_data  = 8'h10 + 8'(i);
        sbq.push_back('{sel: 3'(i), data: 8'h10 + 8'(i)});
      end else begin
        b1.in_valid = 1'b0;
      end
      #1;
      checks++;
      if (b1.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rot_in_ready i=%0d got=%b exp=1", i, b1.in_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (b1.out_valid !== 8'h00 || b1.busy !== 1'b0) begin
      failures++;
      $display("FAIL rot_idle got v=%h b=%b exp v=00 b=0", b1.out_valid, b1.busy);
    end
  endtask

  task automatic test_burst2_sparse;
    logic [2:0] exp_sel [8] = '{3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7, 3'd2, 3'd2};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i == 0) b2.ch_en = 8'b1010_0100;
      if (i > 0) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL b2_sb_empty i=%0d got=empty exp=entry", i);
        end else begin
          exp_e = sbq.pop_front();
          exp_v = 8'h01 << exp_e.sel;
          if (b2.sel !== exp_e.sel || b2.out_data !== exp_e.data || b2.out_valid !== exp_v) begin
            failures++;
            $display("FAIL b2_word i=%0d got s=%0d d=%h v=%h exp s=%0d d=%h v=%h",
                     i, b2.sel, b2.out_data, b2.out_valid, exp_e.sel, exp_e.data, exp_v);
          end
        end
      end
      if (i < 8) begin
        b2.in_valid = 1'b1;
        b2.in_data  = 8'h20 + 8'(i);
        sbq.push_back('{sel: exp_sel[i], data: 8'h20 + 8'(i)});
      end else begin
        b2.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (b2.out_valid !== 8'h00) begin
      failures++;
      $display("FAIL b2_idle got v=%h exp v=00", b2.out_valid);
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    b1.ch_en = 8'h08; b1.out_ready = 8'hF7; b1.in_valid = 1'b1; b1.in_data = 8'hAA;
    sbq.push_back('{sel: 3'd3, data: 8'hAA});
    #1;
    checks++;
    if (b1.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first_ready got=%b exp=1", b1.in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        b1.ch_en = 8'hFF;
        b1.in_data = 8'hBB;
      end
      #1;
      checks++;
      if (b1.out_data !== 8'hAA || b1.out_valid !== 8'h08 || b1.sel !== 3'd3 || b1.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold k=%0d got d=%h v=%h s=%0d rdy=%b exp d=aa v=08 s=3 rdy=0",
                 k, b1.out_data, b1.out_valid, b1.sel, b1.in_ready);
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL bp_sb_empty k=%0d got=empty exp=entry", k);
      end else begin
        exp_e = sbq.pop_front();
        exp_v = 8'h01 << exp_e.sel;
        if (b1.sel !== exp_e.sel || b1.out_data !== exp_e.data || b1.out_valid !== exp_v) begin
          failures++;
          $display("FAIL bp_word k=%0d got s=%0d d=%h v=%h exp s=%0d d=%h v=%h",
                   k, b1.sel, b1.out_data, b1.out_valid, exp_e.sel, exp_e.data, exp_v);
        end
      end
      if (k == 0) begin
        b1.out_ready = 8'hFF;
        sbq.push_back('{sel: 3'd4, data: 8'hBB});
        #1;
        checks++;
        if (b1.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_release_ready got=%b exp=1", b1.in_ready);
        end
      end else begin
        b1.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (b1.out_valid !== 8'h00) begin
      failures++;
      $display("FAIL bp_idle got v=%h exp v=00", b1.out_valid);
    end
  endtask

  task automatic test_no_enable;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        b1.ch_en = 8'h00; b1.in_valid = 1'b1; b1.in_data = 8'hCC;
      end
      #1;
      checks++;
      if (b1.in_ready !== 1'b0 || b1.out_valid !== 8'h00) begin
        failures++;
        $display("FAIL noen_block k=%0d got rdy=%b v=%h exp rdy=0 v=00", k, b1.in_ready, b1.out_valid);
      end
    end
    @(negedge clk);
    b1.ch_en = 8'h40;
    sbq.push_back('{sel: 3'd6, data: 8'hCC});
    #1;
    checks++;
    if (b1.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL noen_enable_ready got=%b exp=1", b1.in_ready);
    end
    @(negedge clk);
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL noen_sb_empty got=empty exp=entry");
    end else begin
      exp_e = sbq.pop_front();
      exp_v = 8'h01 << exp_e.sel;
      if (b1.sel !== exp_e.sel || b1.out_data !== exp_e.data || b1.out_valid !== exp_v) begin
        failures++;
        $display("FAIL noen_word got s=%0d d=%h v=%h exp s=%0d d=%h v=%h",
                 b1.sel, b1.out_data, b1.out_valid, exp_e.sel, exp_e.data, exp_v);
      end
    end
    b1.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_disable_midburst;
    logic [2:0] exp_sel [6] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL mid_sb_empty i=%0d got=empty exp=entry", i);
        end else begin
          exp_e = sbq.pop_front();
          exp_v = 8'h01 << exp_e.sel;
          if (b3.sel !== exp_e.sel || b3.out_data !== exp_e.data || b3.out_valid !== exp_v) begin
            failures++;
            $display("FAIL mid_word i=%0d got s=%0d d=%h v=%h exp s=%0d d=%h v=%h",
                     i, b3.sel, b3.out_data, b3.out_valid, exp_e.sel, exp_e.data, exp_v);
          end
        end
      end
      if (i == 2) b3.ch_en = 8'hFE;
      if (i < 6) begin
        b3.in_valid = 1'b1;
        b3.in_data  = 8'h30 + 8'(i);
        sbq.push_back('{sel: exp_sel[i], data: 8'h30 + 8'(i)});
      end else begin
        b3.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    b1.ch_en = 8'h20; b1.out_ready = 8'h00; b1.in_valid = 1'b1; b1.in_data = 8'h55;
    sbq.push_back('{sel: 3'd5, data: 8'h55});
    @(negedge clk);
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL ar_sb_empty got=empty exp=entry");
    end else begin
      exp_e = sbq.pop_front();
      exp_v = 8'h01 << exp_e.sel;
      if (b1.sel !== exp_e.sel || b1.out_data !== exp_e.data || b1.out_valid !== exp_v) begin
        failures++;
        $display("FAIL ar_held got s=%0d d=%h v=%h exp s=%0d d=%h v=%h",
                 b1.sel, b1.out_data, b1.out_valid, exp_e.sel, exp_e.data, exp_v);
      end
    end
    b1.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b1.out_valid !== 8'h00 || b1.sel !== 3'd0 || b1.out_data !== 8'h00 || b1.busy !== 1'b0) begin
      failures++;
      $display("FAIL ar_async_clear got v=%h s=%0d d=%h b=%b exp v=00 s=0 d=00 b=0",
               b1.out_valid, b1.sel, b1.out_data, b1.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    b1.ch_en = 8'hFF; b1.out_ready = 8'hFF; b1.in_valid = 1'b1; b1.in_data = 8'h66;
    sbq.push_back('{sel: 3'd0, data: 8'h66});
    @(negedge clk);
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL ar_sb_empty2 got=empty exp=entry");
    end else begin
      exp_e = sbq.pop_front();
      exp_v = 8'h01 << exp_e.sel;
      if (b1.sel !== exp_e.sel || b1.out_data !== exp_e.data || b1.out_valid !== exp_v) begin
        failures++;
        $display("FAIL ar_first_after got s=%0d d=%h v=%h exp s=%0d d=%h v=%h",
                 b1.sel, b1.out_data, b1.out_valid, exp_e.sel, exp_e.data, exp_v);
      end
    end
    b1.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", sbq.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_rotation_b1();
    test_burst2_sparse();
    test_backpressure();
    test_no_enable();
    test_disable_midburst();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
